// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline-stage register with a 2-entry skid buffer.
// MAIN drives the outputs, SKID absorbs one overflow entry so in_ready can be
// a flop with no combinational path from out_ready. Saturating stall counter.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned N_DATA = 3,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned CTRL_W = 6,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_DATA*DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]          in_rd,
  input  logic [CTRL_W-1:0]        in_ctrl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_DATA*DATA_W-1:0] out_data,
  output logic [RD_W-1:0]          out_rd,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int unsigned PayW = N_DATA * DATA_W;
  localparam logic [CNT_W-1:0] CntMax = '1;

  // State encodes occupancy of MAIN/SKID.
  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [PayW-1:0]   main_data_q, main_data_d;
  logic [RD_W-1:0]   main_rd_q, main_rd_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [PayW-1:0]   skid_data_q, skid_data_d;
  logic [RD_W-1:0]   skid_rd_q, skid_rd_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic valid;
  logic accept;
  logic pop;

  assign valid  = (state_q != StEmpty);
  assign accept = in_valid & in_ready_q;
  assign pop    = valid & out_ready;

  // Next-state for occupancy FSM and entry registers.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_rd_d   = main_rd_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_rd_d   = skid_rd_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      // Flush wins over accept and pop; any same-cycle accept is dropped.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_data_d = in_data;
            main_rd_d   = in_rd;
            main_ctrl_d = in_ctrl;
            state_d     = StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            main_data_d = in_data;
            main_rd_d   = in_rd;
            main_ctrl_d = in_ctrl;
          end else if (accept) begin
            skid_data_d = in_data;
            skid_rd_d   = in_rd;
            skid_ctrl_d = in_ctrl;
            state_d     = StFull;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            main_data_d = skid_data_q;
            main_rd_d   = skid_rd_q;
            main_ctrl_d = skid_ctrl_q;
            state_d     = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // in_ready is the registered image of the next occupancy.
  always_comb begin
    in_ready_d = (state_d != StFull);
  end

  // Saturating stall counter; deliberately ignores flush.
  always_comb begin
    stall_d = stall_q;
    if (valid && !out_ready && (stall_q != CntMax)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State and entry registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_rd_q   <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_rd_q   <= '0;
      skid_ctrl_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_rd_q   <= main_rd_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_rd_q   <= skid_rd_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_q     <= stall_d;
    end
  end

  // Outputs; rd/ctrl are forced to zero in bubbles.
  always_comb begin
    in_ready  = in_ready_q;
    out_valid = valid;
    out_data  = main_data_q;
    out_rd    = valid ? main_rd_q : '0;
    out_ctrl  = valid ? main_ctrl_q : '0;
    stall_cnt = stall_q;
  end

endmodule
